// File: rtl/rs_pkg.sv
// Reservation-station package: default geometry and the CDB channel record.
//   RS_DEPTH_DEF  : entries per station
//   CDB_CH_DEF    : common-data-bus broadcast channels
//   TAG_W_DEF     : ROB tag width (tag 0 = operand already available)
//   PAYLOAD_W_DEF : opaque decoded-instruction payload width
//   cdb_ch_t      : one CDB channel at default widths
package rs_pkg;
  import sys_defs::*;

  localparam int RS_DEPTH_DEF  = 8;
  localparam int CDB_CH_DEF    = 2;
  localparam int TAG_W_DEF     = 5;
  localparam int PAYLOAD_W_DEF = 96;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    logic [XLEN-1:0]      value;
  } cdb_ch_t;
endpackage

// File: rtl/sys_defs.sv
// System-wide definitions shared by every pipeline block.
//   XLEN : architectural register / operand width
package sys_defs;
  localparam int XLEN = 32;
endpackage

// File: rtl/rs_age_select.sv
// Age-matrix oldest-first selector. Keeps an N x N matrix where
// older_q[i][j] = 1 means entry i was allocated before entry j, and grants
// the ready entry that has no older ready entry.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   clear_i           : drop all ordering (flush)
//   alloc_valid_i     : an entry is being allocated this edge
//   alloc_idx_i       : index of the entry being allocated (must be non-busy)
//   busy_i            : registered busy vector
//   ready_i           : entries eligible for selection
//   grant_valid_o     : some entry is granted
//   grant_o           : one-hot grant
//   grant_idx_o       : binary index of the grant (0 when none)
module rs_age_select #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             alloc_valid_i,
  input  logic [IDX_W-1:0] alloc_idx_i,
  input  logic [N-1:0]     busy_i,
  input  logic [N-1:0]     ready_i,
  output logic             grant_valid_o,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [N-1:0] older_q [N];
  logic [N-1:0] blocked;

  // Every currently busy entry becomes older than the newcomer, and the
  // newcomer's row is wiped so it is older than nothing. Rows of free
  // entries may hold stale bits; they never matter because only busy
  // (ready) entries take part in selection and a row is cleared on reuse.
  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      for (int i = 0; i < N; i++) older_q[i] <= '0;
    end else if (alloc_valid_i) begin
      for (int j = 0; j < N; j++) begin
        if (busy_i[j]) older_q[j][alloc_idx_i] <= 1'b1;
      end
      older_q[alloc_idx_i] <= '0;
    end
  end

  always_comb begin
    blocked     = '0;
    grant_o     = '0;
    grant_idx_o = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (ready_i[j] && older_q[j][i]) blocked[i] = 1'b1;
      end
      if (ready_i[i] && !blocked[i]) grant_o[i] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (grant_o[i]) grant_idx_o = IDX_W'(i);
    end
  end

  assign grant_valid_o = |ready_i;

endmodule

// File: rtl/rs_station.sv
// Multi-entry reservation station. Holds dispatched instructions until both
// source operands are available, snooping the CDB (including same-cycle
// bypass into the entry being written), and issues one ready instruction per
// cycle, oldest first.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; dispatch uses disp_valid/disp_ready, issue uses
// iss_valid/iss_ready. Valid never waits on ready. Issue outputs are
// recomputed every cycle and carry no hold-stability promise.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   squash                : flush every entry (beats dispatch and issue)
//   disp_*                : dispatch request, payload, source tags/values
//   cdb_valid/tag/value   : packed CDB channels, channel 0 in the LSBs
//   iss_*                 : selected entry, index and contents (0 when idle)
//   free_count            : number of non-busy entries
module rs_station
  import rs_pkg::*;
#(
  parameter int RS_DEPTH  = RS_DEPTH_DEF,
  parameter int CDB_CH    = CDB_CH_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int XLEN      = sys_defs::XLEN,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [PAYLOAD_W-1:0]         disp_payload,
  input  logic [TAG_W-1:0]             disp_rs1_tag,
  input  logic [TAG_W-1:0]             disp_rs2_tag,
  input  logic [XLEN-1:0]              disp_rs1_value,
  input  logic [XLEN-1:0]              disp_rs2_value,
  input  logic [CDB_CH-1:0]            cdb_valid,
  input  logic [CDB_CH*TAG_W-1:0]      cdb_tag,
  input  logic [CDB_CH*XLEN-1:0]       cdb_value,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [$clog2(RS_DEPTH)-1:0]  iss_idx,
  output logic [PAYLOAD_W-1:0]         iss_payload,
  output logic [XLEN-1:0]              iss_rs1_value,
  output logic [XLEN-1:0]              iss_rs2_value,
  output logic [$clog2(RS_DEPTH+1)-1:0] free_count
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = $clog2(RS_DEPTH+1);

  logic [RS_DEPTH-1:0]  busy_q, busy_d;
  logic [PAYLOAD_W-1:0] payload_q [RS_DEPTH];
  logic [PAYLOAD_W-1:0] payload_d [RS_DEPTH];
  logic [TAG_W-1:0]     rs1_tag_q [RS_DEPTH];
  logic [TAG_W-1:0]     rs1_tag_d [RS_DEPTH];
  logic [TAG_W-1:0]     rs2_tag_q [RS_DEPTH];
  logic [TAG_W-1:0]     rs2_tag_d [RS_DEPTH];
  logic [XLEN-1:0]      rs1_val_q [RS_DEPTH];
  logic [XLEN-1:0]      rs1_val_d [RS_DEPTH];
  logic [XLEN-1:0]      rs2_val_q [RS_DEPTH];
  logic [XLEN-1:0]      rs2_val_d [RS_DEPTH];

  logic [RS_DEPTH-1:0]  ready_vec;
  logic [RS_DEPTH-1:0]  grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic [IDX_W-1:0]     alloc_idx;
  logic [CNT_W-1:0]     free_cnt;
  logic                 alloc_fire;
  logic                 iss_fire;
  logic [XLEN:0]        snoop1, snoop2;
  logic [XLEN:0]        disp_snoop1, disp_snoop2;

  // Returns {hit, value} for a source tag against all valid CDB channels.
  // Scanning downward lets the lowest matching channel overwrite last and
  // win. A zero source tag never matches, so CDB tag 0 is ignored too.
  function automatic logic [XLEN:0] cdb_snoop(
    input logic [TAG_W-1:0]        tag,
    input logic [CDB_CH-1:0]       v,
    input logic [CDB_CH*TAG_W-1:0] tags,
    input logic [CDB_CH*XLEN-1:0]  vals
  );
    logic [XLEN:0] r;
    r = '0;
    if (tag != '0) begin
      for (int c = CDB_CH-1; c >= 0; c--) begin
        if (v[c] && (tags[c*TAG_W +: TAG_W] == tag)) r = {1'b1, vals[c*XLEN +: XLEN]};
      end
    end
    return r;
  endfunction

  // Ready and free bookkeeping come only from registered state.
  always_comb begin
    ready_vec = '0;
    free_cnt  = '0;
    alloc_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready_vec[i] = busy_q[i] && (rs1_tag_q[i] == '0) && (rs2_tag_q[i] == '0);
      if (!busy_q[i]) free_cnt = free_cnt + CNT_W'(1);
    end
    // Downward scan leaves the lowest free index.
    for (int i = RS_DEPTH-1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign free_count  = free_cnt;
  assign disp_ready  = (free_cnt != '0);
  assign alloc_fire  = disp_valid && disp_ready && !squash;
  assign iss_fire    = grant_valid && iss_ready;
  assign disp_snoop1 = cdb_snoop(disp_rs1_tag, cdb_valid, cdb_tag, cdb_value);
  assign disp_snoop2 = cdb_snoop(disp_rs2_tag, cdb_valid, cdb_tag, cdb_value);

  rs_age_select #(
    .N     (RS_DEPTH),
    .IDX_W (IDX_W)
  ) u_age (
    .clock         (clock),
    .reset         (reset),
    .clear_i       (squash),
    .alloc_valid_i (alloc_fire),
    .alloc_idx_i   (alloc_idx),
    .busy_i        (busy_q),
    .ready_i       (ready_vec),
    .grant_valid_o (grant_valid),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx)
  );

  // Wakeup, issue and allocation touch disjoint concerns of the same edge:
  // the allocated entry is free in registered state, so it is never the one
  // being issued or woken.
  always_comb begin
    busy_d = busy_q;
    snoop1 = '0;
    snoop2 = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      payload_d[i] = payload_q[i];
      rs1_tag_d[i] = rs1_tag_q[i];
      rs2_tag_d[i] = rs2_tag_q[i];
      rs1_val_d[i] = rs1_val_q[i];
      rs2_val_d[i] = rs2_val_q[i];

      snoop1 = cdb_snoop(rs1_tag_q[i], cdb_valid, cdb_tag, cdb_value);
      snoop2 = cdb_snoop(rs2_tag_q[i], cdb_valid, cdb_tag, cdb_value);
      if (busy_q[i] && snoop1[XLEN]) begin
        rs1_tag_d[i] = '0;
        rs1_val_d[i] = snoop1[XLEN-1:0];
      end
      if (busy_q[i] && snoop2[XLEN]) begin
        rs2_tag_d[i] = '0;
        rs2_val_d[i] = snoop2[XLEN-1:0];
      end

      if (iss_fire && grant[i]) busy_d[i] = 1'b0;

      if (alloc_fire && (alloc_idx == IDX_W'(i))) begin
        busy_d[i]    = 1'b1;
        payload_d[i] = disp_payload;
        if (disp_snoop1[XLEN]) begin
          rs1_tag_d[i] = '0;
          rs1_val_d[i] = disp_snoop1[XLEN-1:0];
        end else begin
          rs1_tag_d[i] = disp_rs1_tag;
          rs1_val_d[i] = disp_rs1_value;
        end
        if (disp_snoop2[XLEN]) begin
          rs2_tag_d[i] = '0;
          rs2_val_d[i] = disp_snoop2[XLEN-1:0];
        end else begin
          rs2_tag_d[i] = disp_rs2_tag;
          rs2_val_d[i] = disp_rs2_value;
        end
      end
    end
    if (squash) busy_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        payload_q[i] <= '0;
        rs1_tag_q[i] <= '0;
        rs2_tag_q[i] <= '0;
        rs1_val_q[i] <= '0;
        rs2_val_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < RS_DEPTH; i++) begin
        payload_q[i] <= payload_d[i];
        rs1_tag_q[i] <= rs1_tag_d[i];
        rs2_tag_q[i] <= rs2_tag_d[i];
        rs1_val_q[i] <= rs1_val_d[i];
        rs2_val_q[i] <= rs2_val_d[i];
      end
    end
  end

  assign iss_valid     = grant_valid;
  assign iss_idx       = grant_idx;
  assign iss_payload   = grant_valid ? payload_q[grant_idx] : '0;
  assign iss_rs1_value = grant_valid ? rs1_val_q[grant_idx] : '0;
  assign iss_rs2_value = grant_valid ? rs2_val_q[grant_idx] : '0;

endmodule

// File: tb/tb_rs_station.sv
module tb_rs_station;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic        squash;
  logic        disp_valid;
  logic        disp_ready;
  logic [95:0] disp_payload;
  logic [4:0]  disp_rs1_tag, disp_rs2_tag;
  logic [31:0] disp_rs1_value, disp_rs2_value;
  logic [1:0]  cdb_valid;
  logic [9:0]  cdb_tag;
  logic [63:0] cdb_value;
  logic        iss_valid;
  logic        iss_ready;
  logic [2:0]  iss_idx;
  logic [95:0] iss_payload;
  logic [31:0] iss_rs1_value, iss_rs2_value;
  logic [3:0]  free_count;

  rs_station dut (
    .clock          (clock),
    .reset          (reset),
    .squash         (squash),
    .disp_valid     (disp_valid),
    .disp_ready     (disp_ready),
    .disp_payload   (disp_payload),
    .disp_rs1_tag   (disp_rs1_tag),
    .disp_rs2_tag   (disp_rs2_tag),
    .disp_rs1_value (disp_rs1_value),
    .disp_rs2_value (disp_rs2_value),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_value      (cdb_value),
    .iss_valid      (iss_valid),
    .iss_ready      (iss_ready),
    .iss_idx        (iss_idx),
    .iss_payload    (iss_payload),
    .iss_rs1_value  (iss_rs1_value),
    .iss_rs2_value  (iss_rs2_value),
    .free_count     (free_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  // Entries as slots plus a list of occupied slots in dispatch order.
  bit          m_busy [8];
  logic [95:0] m_pay  [8];
  logic [4:0]  m_t1   [8];
  logic [4:0]  m_t2   [8];
  logic [31:0] m_v1   [8];
  logic [31:0] m_v2   [8];
  int          age_q[$];

  task automatic cdb_lookup(input logic [4:0] tag, output bit hit, output logic [31:0] val);
    hit = 0;
    val = '0;
    if (tag != 0) begin
      for (int c = 0; c < 2; c++) begin
        if (!hit && cdb_valid[c] && cdb_tag[c*5 +: 5] == tag) begin
          hit = 1;
          val = cdb_value[c*32 +: 32];
        end
      end
    end
  endtask

  // Oldest occupied slot whose operands are both available.
  task automatic model_sel(output bit v, output int idx);
    v = 0;
    idx = 0;
    for (int q = 0; q < age_q.size(); q++) begin
      if (!v && m_t1[age_q[q]] == 0 && m_t2[age_q[q]] == 0) begin
        v = 1;
        idx = age_q[q];
      end
    end
  endtask

  function automatic int model_free();
    int n = 0;
    for (int i = 0; i < 8; i++) if (!m_busy[i]) n++;
    return n;
  endfunction

  task automatic model_edge();
    bit sv, hit;
    int si, k, pos;
    logic [31:0] hv;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_busy[i] = 0; m_pay[i] = '0; m_t1[i] = 0; m_t2[i] = 0; m_v1[i] = 0; m_v2[i] = 0;
      end
      age_q.delete();
      return;
    end
    model_sel(sv, si);
    k = -1;
    for (int i = 7; i >= 0; i--) if (!m_busy[i]) k = i;
    if (squash) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 0;
      age_q.delete();
      return;
    end
    for (int i = 0; i < 8; i++) begin
      if (m_busy[i]) begin
        cdb_lookup(m_t1[i], hit, hv);
        if (hit) begin m_t1[i] = 0; m_v1[i] = hv; end
        cdb_lookup(m_t2[i], hit, hv);
        if (hit) begin m_t2[i] = 0; m_v2[i] = hv; end
      end
    end
    if (sv && iss_ready) begin
      m_busy[si] = 0;
      pos = -1;
      for (int q = 0; q < age_q.size(); q++) if (age_q[q] == si) pos = q;
      if (pos >= 0) age_q.delete(pos);
    end
    if (disp_valid && k >= 0) begin
      m_busy[k] = 1;
      m_pay[k] = disp_payload;
      cdb_lookup(disp_rs1_tag, hit, hv);
      if (hit) begin m_t1[k] = 0; m_v1[k] = hv; end
      else begin m_t1[k] = disp_rs1_tag; m_v1[k] = disp_rs1_value; end
      cdb_lookup(disp_rs2_tag, hit, hv);
      if (hit) begin m_t2[k] = 0; m_v2[k] = hv; end
      else begin m_t2[k] = disp_rs2_tag; m_v2[k] = disp_rs2_value; end
      age_q.push_back(k);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    squash = 0; disp_valid = 0; disp_payload = '0;
    disp_rs1_tag = 0; disp_rs2_tag = 0; disp_rs1_value = 0; disp_rs2_value = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0; iss_ready = 0;
  endtask

  task automatic drive_disp(input logic [95:0] p, input logic [4:0] t1, input logic [4:0] t2,
                            input logic [31:0] v1, input logic [31:0] v2);
    disp_valid = 1; disp_payload = p;
    disp_rs1_tag = t1; disp_rs2_tag = t2; disp_rs1_value = v1; disp_rs2_value = v2;
  endtask

  task automatic drive_cdb(input int ch, input logic [4:0] t, input logic [31:0] v);
    cdb_valid[ch] = 1'b1;
    cdb_tag[ch*5 +: 5] = t;
    cdb_value[ch*32 +: 32] = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    n_checks++; if (iss_valid !== 1'b0) begin n_errors++; $display("FAIL reset_iss_valid got %0b want 0", iss_valid); end
    n_checks++; if (disp_ready !== 1'b1) begin n_errors++; $display("FAIL reset_disp_ready got %0b want 1", disp_ready); end
    n_checks++; if (free_count !== 4'd8) begin n_errors++; $display("FAIL reset_free_count got %0d want 8", free_count); end
    n_checks++; if (iss_payload !== 96'd0 || iss_idx !== 3'd0 || iss_rs1_value !== 0 || iss_rs2_value !== 0) begin
      n_errors++; $display("FAIL reset_iss_zero got idx %0d pay %h", iss_idx, iss_payload); end
  endtask

  task automatic test_ready_dispatch();
    drive_disp(96'hA, 0, 0, 32'd5, 32'd7);
    tick();
    disp_valid = 0;
    n_checks++; if (iss_valid !== 1'b1) begin n_errors++; $display("FAIL rd_iss_valid got %0b want 1", iss_valid); end
    n_checks++; if (iss_rs1_value !== 32'd5 || iss_rs2_value !== 32'd7) begin
      n_errors++; $display("FAIL rd_values got %0d/%0d want 5/7", iss_rs1_value, iss_rs2_value); end
    n_checks++; if (iss_payload !== 96'hA || iss_idx !== 3'd0) begin
      n_errors++; $display("FAIL rd_payload got %h idx %0d want a idx 0", iss_payload, iss_idx); end
    n_checks++; if (free_count !== 4'd7) begin n_errors++; $display("FAIL rd_free got %0d want 7", free_count); end
    iss_ready = 1;
    tick();
    iss_ready = 0;
    n_checks++; if (free_count !== 4'd8 || iss_valid !== 1'b0) begin
      n_errors++; $display("FAIL rd_after_issue got free %0d valid %0b want 8 0", free_count, iss_valid); end
  endtask

  task automatic test_wakeup_bypass();
    // broadcast two cycles after dispatch
    drive_disp(96'hB, 5'd3, 0, 32'hDEAD, 32'd9);
    tick();
    disp_valid = 0;
    n_checks++; if (iss_valid !== 1'b0) begin n_errors++; $display("FAIL wk_wait got %0b want 0", iss_valid); end
    tick();
    drive_cdb(1, 5'd3, 32'h55);
    n_checks++; if (iss_valid !== 1'b0) begin n_errors++; $display("FAIL wk_bcast_cycle got %0b want 0", iss_valid); end
    tick();
    cdb_valid = 0;
    n_checks++; if (iss_valid !== 1'b1 || iss_rs1_value !== 32'h55 || iss_rs2_value !== 32'd9) begin
      n_errors++; $display("FAIL wk_woken got v %0b rs1 %h rs2 %0d want 1 55 9", iss_valid, iss_rs1_value, iss_rs2_value); end
    iss_ready = 1; tick(); iss_ready = 0;
    // broadcast in the dispatch cycle itself
    drive_disp(96'hC, 5'd3, 0, 32'hDEAD, 32'd1);
    drive_cdb(1, 5'd3, 32'h66);
    tick();
    disp_valid = 0; cdb_valid = 0;
    n_checks++; if (iss_valid !== 1'b1 || iss_rs1_value !== 32'h66) begin
      n_errors++; $display("FAIL wk_bypass got v %0b rs1 %h want 1 66", iss_valid, iss_rs1_value); end
    iss_ready = 1; tick(); iss_ready = 0;
    // two channels carry the same tag: channel 0 wins
    drive_disp(96'hD, 0, 5'd4, 32'd2, 32'hDEAD);
    tick();
    disp_valid = 0;
    drive_cdb(0, 5'd4, 32'h11);
    drive_cdb(1, 5'd4, 32'h22);
    tick();
    cdb_valid = 0;
    n_checks++; if (iss_valid !== 1'b1 || iss_rs2_value !== 32'h11) begin
      n_errors++; $display("FAIL wk_chan_prio got v %0b rs2 %h want 1 11", iss_valid, iss_rs2_value); end
    iss_ready = 1; tick(); iss_ready = 0;
    n_checks++; if (free_count !== 4'd8) begin n_errors++; $display("FAIL wk_drained got %0d want 8", free_count); end
  endtask

  task automatic test_age_order();
    for (int i = 0; i < 8; i++) begin
      drive_disp(96'h100 + 96'(i), 5'd9, 0, $urandom, 32'(i));
      tick();
    end
    disp_valid = 0;
    n_checks++; if (free_count !== 4'd0 || disp_ready !== 1'b0 || iss_valid !== 1'b0) begin
      n_errors++; $display("FAIL age_full got free %0d rdy %0b v %0b want 0 0 0", free_count, disp_ready, iss_valid); end
    drive_cdb(0, 5'd9, 32'h900);
    tick();
    cdb_valid = 0;
    iss_ready = 1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (iss_valid !== 1'b1 || iss_payload !== 96'h100 + 96'(i) || iss_rs1_value !== 32'h900) begin
        n_errors++; $display("FAIL age_order_%0d got v %0b pay %h rs1 %h want 1 %h 900", i, iss_valid, iss_payload, iss_rs1_value, 96'h100 + 96'(i)); end
      tick();
    end
    iss_ready = 0;
    n_checks++; if (free_count !== 4'd8 || iss_valid !== 1'b0) begin
      n_errors++; $display("FAIL age_drained got free %0d v %0b want 8 0", free_count, iss_valid); end
  endtask

  task automatic test_full_recycle();
    for (int i = 0; i < 8; i++) begin
      drive_disp(96'h200 + 96'(i), 0, 0, 32'(i), 32'(i));
      tick();
    end
    drive_disp(96'hDEAD, 0, 0, 0, 0);
    tick(); tick();
    n_checks++; if (free_count !== 4'd0 || disp_ready !== 1'b0 || iss_payload !== 96'h200) begin
      n_errors++; $display("FAIL full_hold got free %0d rdy %0b pay %h want 0 0 200", free_count, disp_ready, iss_payload); end
    disp_valid = 0;
    iss_ready = 1; tick(); iss_ready = 0;
    n_checks++; if (disp_ready !== 1'b1 || free_count !== 4'd1 || iss_idx !== 3'd1) begin
      n_errors++; $display("FAIL full_freed got rdy %0b free %0d idx %0d want 1 1 1", disp_ready, free_count, iss_idx); end
    drive_disp(96'h2FF, 0, 0, 0, 0);
    tick();
    disp_valid = 0;
    n_checks++; if (free_count !== 4'd0) begin n_errors++; $display("FAIL full_refill got %0d want 0", free_count); end
    iss_ready = 1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i < 7) begin
        if (iss_payload !== 96'h201 + 96'(i) || iss_idx !== 3'(i + 1)) begin
          n_errors++; $display("FAIL recycle_order_%0d got pay %h idx %0d want %h %0d", i, iss_payload, iss_idx, 96'h201 + 96'(i), i + 1); end
      end else begin
        if (iss_payload !== 96'h2FF || iss_idx !== 3'd0) begin
          n_errors++; $display("FAIL recycle_last got pay %h idx %0d want 2ff 0", iss_payload, iss_idx); end
      end
      tick();
    end
    iss_ready = 0;
  endtask

  task automatic test_squash();
    for (int i = 0; i < 5; i++) begin
      drive_disp(96'h300 + 96'(i), 0, 0, 0, 0);
      tick();
    end
    disp_valid = 0;
    n_checks++; if (free_count !== 4'd3 || iss_payload !== 96'h300) begin
      n_errors++; $display("FAIL sq_pre got free %0d pay %h want 3 300", free_count, iss_payload); end
    squash = 1; iss_ready = 1;
    drive_disp(96'hBAD, 0, 0, 0, 0);
    tick();
    idle_inputs();
    n_checks++; if (free_count !== 4'd8 || iss_valid !== 1'b0 || disp_ready !== 1'b1 || iss_payload !== 96'd0) begin
      n_errors++; $display("FAIL sq_flush got free %0d v %0b rdy %0b pay %h want 8 0 1 0", free_count, iss_valid, disp_ready, iss_payload); end
    tick();
    n_checks++; if (iss_valid !== 1'b0 || free_count !== 4'd8) begin
      n_errors++; $display("FAIL sq_absent got v %0b free %0d want 0 8", iss_valid, free_count); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      drive_disp(96'h400 + 96'(i), 0, 5'd2, 32'd1, 32'd1);
      tick();
    end
    reset = 1; iss_ready = 1;
    drive_disp(96'h4FF, 0, 0, 0, 0);
    drive_cdb(0, 5'd2, 32'h77);
    tick();
    reset = 0;
    idle_inputs();
    n_checks++; if (free_count !== 4'd8 || iss_valid !== 1'b0 || iss_rs1_value !== 0 || iss_rs2_value !== 0) begin
      n_errors++; $display("FAIL mid_reset got free %0d v %0b want 8 0", free_count, iss_valid); end
  endtask

  task automatic test_random();
    bit ev;
    int ei;
    for (int cyc = 0; cyc < 600; cyc++) begin
      squash = ($urandom_range(0, 59) == 0);
      disp_valid = ($urandom_range(0, 2) != 0);
      disp_payload = {$urandom, $urandom, $urandom};
      disp_rs1_tag = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
      disp_rs2_tag = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
      disp_rs1_value = $urandom;
      disp_rs2_value = $urandom;
      cdb_valid = 2'($urandom_range(0, 3));
      cdb_tag = {5'($urandom_range(0, 6)), 5'($urandom_range(0, 6))};
      cdb_value = {$urandom, $urandom};
      iss_ready = ($urandom_range(0, 2) != 0);
      model_sel(ev, ei);
      n_checks++; if (iss_valid !== ev) begin
        n_errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", cyc, iss_valid, ev); end
      n_checks++; if (iss_idx !== (ev ? 3'(ei) : 3'd0)) begin
        n_errors++; $display("FAIL rnd_idx cyc %0d got %0d want %0d", cyc, iss_idx, ev ? ei : 0); end
      n_checks++; if (iss_payload !== (ev ? m_pay[ei] : 96'd0)) begin
        n_errors++; $display("FAIL rnd_payload cyc %0d got %h", cyc, iss_payload); end
      n_checks++; if (iss_rs1_value !== (ev ? m_v1[ei] : 32'd0) || iss_rs2_value !== (ev ? m_v2[ei] : 32'd0)) begin
        n_errors++; $display("FAIL rnd_values cyc %0d got %h/%h want %h/%h", cyc, iss_rs1_value, iss_rs2_value,
                             ev ? m_v1[ei] : 32'd0, ev ? m_v2[ei] : 32'd0); end
      n_checks++; if (free_count !== 4'(model_free()) || disp_ready !== (model_free() != 0)) begin
        n_errors++; $display("FAIL rnd_free cyc %0d got %0d rdy %0b want %0d", cyc, free_count, disp_ready, model_free()); end
      tick();
    end
    idle_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_ready_dispatch();
    test_wakeup_bypass();
    test_age_order();
    test_full_recycle();
    test_squash();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rs_station.md
# rs_station

Parametrised multi-entry reservation station holding up to RS_DEPTH dispatched instructions until their source operands are available. It sits between dispatch (decoder, map table, ROB) and the issue/execute stage. It snoops CDB_CH common-data-bus channels, including same-cycle bypass into the entry being written, and issues one ready instruction per cycle, oldest first, through a valid/ready handshake. A squash input flushes every entry.

## Interface
- RS_DEPTH, 8, number of entries (≥2)
- CDB_CH, 2, number of CDB broadcast channels (≥1)
- TAG_W, 5, ROB tag width; tag 0 means operand ready
- XLEN, 32, operand value width
- PAYLOAD_W, 96, opaque decoded-instruction payload width (includes destination ROB tag)

Ports:
- clock  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- squash  in  1  flush all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  at least one free entry
- disp_payload  in  PAYLOAD_W  instruction fields
- disp_rs1_tag, disp_rs2_tag  in  TAG_W each  source tags from map table, 0 = ready
- disp_rs1_value, disp_rs2_value  in  XLEN each  source values, meaningful when tag = 0
- cdb_valid  in  CDB_CH  per-channel broadcast valid
- cdb_tag  in  CDB_CH*TAG_W  packed broadcast tags, channel 0 in LSBs
- cdb_value  in  CDB_CH*XLEN  packed broadcast values
- iss_valid  out  1  an entry is ready to issue
- iss_ready  in  1  issue stage accepts
- iss_idx  out  $clog2(RS_DEPTH)  selected entry index
- iss_payload  out  PAYLOAD_W; iss_rs1_value, iss_rs2_value  out  XLEN each  selected entry contents
- free_count  out  $clog2(RS_DEPTH+1)  number of non-busy entries

## Operation
- Per-entry state: busy, payload, rs1/rs2 tag, rs1/rs2 value. Age matrix older[i][j] = 1 means entry i is older than entry j.
- Allocation: when disp_valid && disp_ready && !squash, write the lowest-index non-busy entry. Set its busy bit. For every busy j, set older[j][k] = 1; set older[k][*] = 0.
- Dispatch bypass: for each source with tag ≠ 0, if a valid CDB channel carries that tag in the same cycle, store tag 0 and that channel's value. Otherwise store the tag, and the value as given.
- Wakeup: each busy entry compares each nonzero source tag against every valid channel. On a match, the tag becomes 0 and the value is captured. If several channels match, the lowest channel index wins. A CDB tag of 0 is ignored.
- Ready: entry is busy and both tags are 0. Both are computed from registered state.
- Select: iss_valid = any ready entry. The chosen entry is the ready entry with no older ready entry. iss_* outputs reflect that entry combinationally. When iss_valid is 0, iss_* outputs are 0.
- Issue: iss_valid && iss_ready clears the chosen entry's busy bit at the edge. Tags and values are don't-care once the entry is free.
- Selection is recomputed every cycle. The consumer samples in the handshake cycle. No hold-stability guarantee.
- disp_ready = free_count ≠ 0, from registered busy bits. An entry freed by issue is reusable the next cycle, not the same cycle.
- Squash: all busy bits and the age matrix are 0 next edge. Squash overrides a same-cycle dispatch, which is dropped, and a same-cycle issue.
- Reset values: busy 0, tags 0, values 0, age matrix 0. Therefore iss_valid 0, all iss_* 0, disp_ready 1, free_count RS_DEPTH.

## Timing
- Dispatch with both sources ready (or bypassed) at edge t → iss_valid in cycle t+1.
- CDB broadcast in cycle t → dependent entry eligible in cycle t+1.
- Issue handshake at edge t → entry free in cycle t+1, free_count +1.
- Full: free_count 0, disp_ready 0. Dispatch while full is ignored.
- Simultaneous dispatch, issue and wakeup are all honoured in the same edge.
- Reset asserted mid-operation overrides everything and produces reset values at the next edge.

## Structure
- Shared package rs_pkg: RS_DEPTH, CDB_CH, TAG_W defaults, and the CDB channel struct. XLEN comes from sys_defs.
- Sub-module rs_age_select: holds the age matrix, takes the ready vector, and produces a one-hot grant plus index. It is reusable by future load/store queues.

## Test plan
- Reset: after reset → iss_valid 0, disp_ready 1, free_count 8.
- Ready dispatch: dispatch payload 0xA, tags 0/0, values 5/7 → next cycle iss_valid 1, iss_rs1_value 5, iss_rs2_value 7. Accept → free_count returns to 8.
- Wakeup and bypass: dispatch with rs1_tag 3. Broadcast tag 3, value 0x55 on channel 1 two cycles later → iss_valid the following cycle with rs1 value 0x55. Repeat with the broadcast in the dispatch cycle → eligible at t+1.
- Age order: fill all 8 entries with tags 9 each, then broadcast tag 9 → issues occur in dispatch order across 8 accepts, with iss_ready held 1.
- Full and recycle: fill all 8 entries, then hold disp_valid → disp_ready 0 and nothing is written. Issue one → disp_ready 1 the next cycle, and the new entry lands in the freed index.
- Squash: 5 busy entries, with squash, dispatch and issue in the same cycle → next cycle free_count 8, iss_valid 0, dispatched instruction absent.
